// File: rtl/alu_if.sv
// Operand/result bundle between the control unit and the ALU.
// The master drives operands, op select and the operate strobe; the slave returns result and zero flag.
interface alu_if #(
  parameter int N = 16
);
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [1:0]   op;
  logic         operar;
  logic [N-1:0] out;
  logic         z;

  modport master (output in_a, in_b, op, operar, input out, z);
  modport slave  (input in_a, in_b, op, operar, output out, z);
endinterface

// File: rtl/alu.sv
// N-bit ALU (add, sub, arithmetic shift right by one, AND).
// The result and zero flag are registered, and they update only on operate-strobe edges.
module alu #(
  parameter int N = 16
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_SRA = 2'b10,
    OP_AND = 2'b11
  } op_e;

  logic [N-1:0] res;
  logic [N-1:0] out_d, out_q;
  logic         z_d, z_q;

  always_comb begin
    res = '0;
    case (op_e'(bus.op))
      OP_ADD:  res = bus.in_a + bus.in_b;
      OP_SUB:  res = bus.in_a - bus.in_b;
      OP_SRA:  res = {bus.in_a[N-1], bus.in_a[N-1:1]};
      OP_AND:  res = bus.in_a & bus.in_b;
      default: res = '0;
    endcase
  end

  // z is only ever loaded together with out, so the flag always describes the value on out.
  always_comb begin
    out_d = out_q;
    z_d   = z_q;
    if (bus.operar) begin
      out_d = res;
      z_d   = (res == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      z_q   <= 1'b0;
    end else begin
      out_q <= out_d;
      z_q   <= z_d;
    end
  end

  assign bus.out = out_q;
  assign bus.z   = z_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: random stimulus against an arithmetic reference model,
// plus directed boundary, hold, reset and latency cases with literal expectations.
module tb_alu;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [N-1:0] exp_out;
  logic         exp_z;

  alu_if #(.N(N)) bus ();
  alu #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [N-1:0] ref_r(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [1:0] o);
    int sa, r;
    case (o)
      2'd0: r = (int'(a) + int'(b)) % 65536;
      2'd1: r = (int'(a) - int'(b) + 65536) % 65536;
      2'd2: begin
        sa = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
        r  = (sa >= 0) ? sa / 2 : -((-sa + 1) / 2);
        r  = (r + 65536) % 65536;
      end
      default: r = int'(a & b);
    endcase
    return r[N-1:0];
  endfunction

  task automatic check(input string nm, input logic [N-1:0] got_o, input logic got_z,
                       input logic [N-1:0] want_o, input logic want_z);
    checks++;
    if (got_o !== want_o || got_z !== want_z) begin
      errors++;
      $display("FAIL %s: got out=%h z=%b, want out=%h z=%b at %0t",
               nm, got_o, got_z, want_o, want_z, $time);
    end
  endtask

  // Reference model: reset clears, an edge with the strobe high captures, any other edge holds.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_out = '0;
      exp_z   = 1'b0;
    end else if (bus.operar === 1'b1) begin
      exp_out = ref_r(bus.in_a, bus.in_b, bus.op);
      exp_z   = (exp_out == '0);
    end
  end

  always @(posedge clk) begin
    #1;
    check("model", bus.out, bus.z, exp_out, exp_z);
  end

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] o,
                       input logic [N-1:0] eo, input logic ez, input string nm);
    @(negedge clk);
    bus.in_a = a; bus.in_b = b; bus.op = o; bus.operar = 1'b1;
    @(posedge clk);
    #1;
    check(nm, bus.out, bus.z, eo, ez);
    check({nm, "_ref"}, exp_out, exp_z, eo, ez);
  endtask

  initial begin
    bus.in_a = '0; bus.in_b = '0; bus.op = 2'b00; bus.operar = 1'b0;
    #1;
    check("reset_init", bus.out, bus.z, 16'h0000, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_op(16'd10, 16'd5, 2'b00, 16'd15, 1'b0, "pos_add");
    do_op(16'd10, 16'd5, 2'b01, 16'd5,  1'b0, "pos_sub");
    do_op(16'd10, 16'd5, 2'b10, 16'd5,  1'b0, "pos_sra");
    do_op(16'd10, 16'd5, 2'b11, 16'd0,  1'b1, "pos_and");
    do_op(16'hFFF6, 16'd5, 2'b00, 16'hFFFB, 1'b0, "neg_add");
    do_op(16'hFFF6, 16'd5, 2'b01, 16'hFFF1, 1'b0, "neg_sub");
    do_op(16'hFFF6, 16'd5, 2'b10, 16'hFFFB, 1'b0, "neg_sra");
    do_op(16'hFFF6, 16'd5, 2'b11, 16'h0004, 1'b0, "neg_and");

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.operar = 1'b0; bus.op = 2'(i % 3);
      bus.in_a = 16'($urandom); bus.in_b = 16'($urandom);
      @(posedge clk);
      #1;
      check("hold", bus.out, bus.z, 16'h0004, 1'b0);
    end

    do_op(16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1, "wrap_add");
    do_op(16'h0000, 16'h0001, 2'b01, 16'hFFFF, 1'b0, "wrap_sub");
    do_op(16'h8000, 16'h1234, 2'b10, 16'hC000, 1'b0, "sra_min");
    do_op(16'h7FFF, 16'h0001, 2'b00, 16'h8000, 1'b0, "ovf_add");
    do_op(16'h0001, 16'h0000, 2'b10, 16'h0000, 1'b1, "sra_one");
    do_op(16'hFFFF, 16'h0000, 2'b10, 16'hFFFF, 1'b0, "sra_ones");

    // Latency: inputs change twice inside one cycle; only the values at the edge count.
    @(negedge clk);
    bus.in_a = 16'd100; bus.in_b = 16'd1; bus.op = 2'b00; bus.operar = 1'b1;
    #2;
    check("lat_before", bus.out, bus.z, 16'hFFFF, 1'b0);
    bus.in_a = 16'd40; bus.in_b = 16'd8; bus.op = 2'b01;
    @(posedge clk);
    #1;
    check("lat_after", bus.out, bus.z, 16'd32, 1'b0);

    // Asynchronous reset in mid-cycle, then hold with the strobe low.
    @(negedge clk);
    bus.operar = 1'b1; bus.op = 2'b00; bus.in_a = 16'd3; bus.in_b = 16'd4;
    #2;
    rst = 1'b1;
    #1;
    check("reset_async", bus.out, bus.z, 16'h0000, 1'b0);
    @(negedge clk);
    check("reset_held", bus.out, bus.z, 16'h0000, 1'b0);
    bus.operar = 1'b0;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_hold", bus.out, bus.z, 16'h0000, 1'b0);
    end

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      case ($urandom_range(0, 5))
        0:       bus.in_a = 16'h8000;
        1:       bus.in_a = 16'hFFFF;
        2:       bus.in_a = 16'h0001;
        default: bus.in_a = 16'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0:       bus.in_b = 16'h0000;
        1:       bus.in_b = bus.in_a;
        default: bus.in_b = 16'($urandom);
      endcase
      bus.op     = 2'($urandom_range(0, 3));
      bus.operar = ($urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    bus.operar = 1'b0;
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
